misr_compactor: RTL and testbench
=================================

MISR_COMPACTOR -- requirements
Module: misr_compactor

Interface
REQ-001 SHALL have parameter WIDTH, default 39, giving the compared response width in bits.
REQ-002 SHALL have parameter CNT_W, default 17, giving the sample and fail counter width in bits.
REQ-003 SHALL have parameter NSAMP, default 100000, giving the samples per session (1 <= NSAMP <= 2^CNT_W).
REQ-004 SHALL have parameter POLY, default 39'h0000000011, giving the MISR feedback taps (x^39+x^4+1).
REQ-005 SHALL have port CK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port start, input, 1 bit: begins a new session.
REQ-008 SHALL have port valid, input, 1 bit: marks diff/resp as one sample this cycle.
REQ-009 SHALL have port diff, input, WIDTH bits: nominal-vs-DFT output XOR vector.
REQ-010 SHALL have port resp, input, WIDTH bits: DFT circuit outputs, compacted into the signature.
REQ-011 SHALL have port busy, output, 1 bit: high in RUN.
REQ-012 SHALL have port done, output, 1 bit: high in DONE.
REQ-013 SHALL have port fail, output, 1 bit: high once any sample had diff != 0.
REQ-014 SHALL have port fail_count, output, CNT_W bits: number of failing samples, saturating.
REQ-015 SHALL have port first_fail_idx, output, CNT_W bits: index of the first failing sample.
REQ-016 SHALL have port first_fail_vec, output, WIDTH bits: diff of the first failing sample.
REQ-017 SHALL have port signature, output, WIDTH bits: MISR state.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE; busy = (state==RUN); done = (state==DONE).
REQ-019 SHALL, on start in any state, enter RUN next edge and zero the sample index, fail, fail_count, first_fail_idx, first_fail_vec and signature.
REQ-020 SHALL give start priority over valid in the same cycle; that sample is dropped.
REQ-021 SHALL ignore valid in IDLE and DONE; all outputs hold.
REQ-022 SHALL, per accepted sample in RUN, set signature <= {sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0) ^ resp.
REQ-023 SHALL, per accepted sample with diff != 0, increment fail_count, saturating at all-ones (no wrap), and set fail.
REQ-024 SHALL capture first_fail_idx = current sample index and first_fail_vec = diff only on the first failing sample of a session; later failures do not overwrite them.
REQ-025 SHALL, on the accepted sample with index NSAMP-1, apply that sample's updates and enter DONE on the same edge (latency zero cycles after the last valid).
REQ-026 SHALL hold DONE with all results stable until start or RST.
REQ-027 SHALL count index 0..NSAMP-1 and never wrap it within a session.

Reset
REQ-028 SHALL, on RST assertion, immediately (asynchronously) force state IDLE and zero every output and internal register, including mid-session.
REQ-029 SHALL, after RST deassertion, remain in IDLE until start.

Configuration
REQ-030 SHALL, with macro MISR_SIGNATURE_EN defined, implement the signature MISR as per REQ-022.
REQ-031 SHALL, without MISR_SIGNATURE_EN, omit the MISR register, ignore resp and tie signature to 0; all other behaviour is unchanged.

Verification
REQ-032 SHALL check: NSAMP=4, start, then 4 valids with diff=0 and resp=0 -> done=1 after the 4th edge, fail=0, fail_count=0, signature=0.
REQ-033 SHALL check: NSAMP=4, resp=1 on sample 0 then zeros -> signature 0x1, 0x2, 0x4, 0x8; and resp=1<<38 on sample 0 then zeros -> signature 0x11, 0x22, 0x44 after samples 1..3.
REQ-034 SHALL check: NSAMP=4, diff = 0, 0x5, 0x1, 0 -> fail=1, fail_count=2, first_fail_idx=1, first_fail_vec=0x5.
REQ-035 SHALL check: CNT_W=3, NSAMP=8, diff=1 on every sample -> fail_count saturates at 7 and does not wrap to 0.
REQ-036 SHALL check: RST pulse after 2 samples -> all outputs 0 with no clock edge needed, and later valids ignored until start; and start+valid in the same cycle mid-RUN -> counters zeroed and that sample not counted.
REQ-037 SHALL check: with MISR_SIGNATURE_EN undefined, rerun REQ-033 stimulus -> signature stays 0 and fail logic matches REQ-034.

Source files
------------

// File: rtl/misr_compactor.sv
// Response compactor: counts failing samples, latches the first failure and
// folds responses into a MISR signature. Define MISR_SIGNATURE_EN to build the MISR.
module misr_compactor #(
  parameter int               WIDTH = 39,
  parameter int               CNT_W = 17,
  parameter int               NSAMP = 100000,
  parameter logic [WIDTH-1:0] POLY  = 39'h0000000011
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  input  logic             valid,
  input  logic [WIDTH-1:0] diff,
  input  logic [WIDTH-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_vec,
  output logic [WIDTH-1:0] signature
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(NSAMP - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_idx;
  logic             r_fail;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [CNT_W-1:0] r_ff_idx;
  logic [WIDTH-1:0] r_ff_vec;
  logic             w_accept;
  logic             w_last;
  logic             w_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_accept = (r_state == RUN) && valid && !start;
  assign w_last   = (r_idx == IDX_LAST);
  assign w_hit    = |diff;

  always_ff @(posedge CK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start)                   w_state_nxt = RUN;
    else if (w_accept && w_last) w_state_nxt = DONE;
  end

  // Sample index and failure bookkeeping; start always wins over a same-cycle sample
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_idx      <= '0;
      r_fail     <= 1'b0;
      r_fail_cnt <= '0;
      r_ff_idx   <= '0;
      r_ff_vec   <= '0;
    end else if (start) begin
      r_idx      <= '0;
      r_fail     <= 1'b0;
      r_fail_cnt <= '0;
      r_ff_idx   <= '0;
      r_ff_vec   <= '0;
    end else if (w_accept) begin
      if (!w_last) r_idx <= r_idx + CNT_W'(1);
      if (w_hit) begin
        r_fail     <= 1'b1;
        r_fail_cnt <= sat_inc(r_fail_cnt);
        if (!r_fail) begin
          r_ff_idx <= r_idx;
          r_ff_vec <= diff;
        end
      end
    end
  end

`ifdef MISR_SIGNATURE_EN
  logic [WIDTH-1:0] r_sig;

  function automatic logic [WIDTH-1:0] misr_next(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] r);
    return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0) ^ r;
  endfunction

  always_ff @(posedge CK or posedge RST) begin
    if (RST)           r_sig <= '0;
    else if (start)    r_sig <= '0;
    else if (w_accept) r_sig <= misr_next(r_sig, resp);
  end

  assign signature = r_sig;
`else
  logic w_unused_resp;
  assign w_unused_resp = ^resp;
  assign signature     = '0;
`endif

  assign busy           = (r_state == RUN);
  assign done           = (r_state == DONE);
  assign fail           = r_fail;
  assign fail_count     = r_fail_cnt;
  assign first_fail_idx = r_ff_idx;
  assign first_fail_vec = r_ff_vec;

endmodule

// File: tb/tb_misr_compactor.sv
// Directed bench for misr_compactor: dut_a (NSAMP=4) and dut_b (CNT_W=3, NSAMP=8)
// share one stimulus stream.
module tb_misr_compactor;

  logic        CK;
  logic        RST;
  logic        start;
  logic        valid;
  logic [38:0] diff;
  logic [38:0] resp;

  logic        busy_a, done_a, fail_a;
  logic [16:0] cnt_a, ffi_a;
  logic [38:0] ffv_a, sig_a;
  logic        busy_b, done_b, fail_b;
  logic [2:0]  cnt_b, ffi_b;
  logic [38:0] ffv_b, sig_b;

  int n_err = 0;
  int n_chk = 0;

  misr_compactor #(.WIDTH(39), .CNT_W(17), .NSAMP(4)) dut_a (
    .CK(CK), .RST(RST), .start(start), .valid(valid), .diff(diff), .resp(resp),
    .busy(busy_a), .done(done_a), .fail(fail_a), .fail_count(cnt_a),
    .first_fail_idx(ffi_a), .first_fail_vec(ffv_a), .signature(sig_a)
  );

  misr_compactor #(.WIDTH(39), .CNT_W(3), .NSAMP(8)) dut_b (
    .CK(CK), .RST(RST), .start(start), .valid(valid), .diff(diff), .resp(resp),
    .busy(busy_b), .done(done_b), .fail(fail_b), .fail_count(cnt_b),
    .first_fail_idx(ffi_b), .first_fail_vec(ffv_b), .signature(sig_b)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_sig(input logic [63:0] v);
`ifdef MISR_SIGNATURE_EN
    return v;
`else
    return 64'(v - v);
`endif
  endfunction

  task automatic cyc(input logic s, input logic v, input logic [38:0] d, input logic [38:0] r);
    @(negedge CK);
    start = s; valid = v; diff = d; resp = r;
    @(posedge CK);
    #1;
    start = 1'b0; valid = 1'b0; diff = '0; resp = '0;
  endtask

  logic [63:0] sig_tab_a [4];
  logic [63:0] sig_tab_b [4];
  logic [38:0] dv    [4];

  initial begin
    RST = 1'b1; start = 1'b0; valid = 1'b0; diff = '0; resp = '0;
    sig_tab_a = '{64'h1, 64'h2, 64'h4, 64'h8};
    sig_tab_b = '{64'h40_0000_0000, 64'h11, 64'h22, 64'h44};
    dv        = '{39'h0, 39'h5, 39'h1, 39'h0};

    repeat (2) @(posedge CK);
    #1;
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_fail", 64'(fail_a), 64'd0);
    chk("rst_cnt",  64'(cnt_a),  64'd0);
    chk("rst_sig",  64'(sig_a),  64'd0);
    @(negedge CK);
    RST = 1'b0;

    cyc(0, 1, 39'h5, 39'h1);
    chk("idle_busy", 64'(busy_a), 64'd0);
    chk("idle_fail", 64'(fail_a), 64'd0);
    chk("idle_sig",  64'(sig_a),  64'd0);

    // all-zero session
    cyc(1, 0, '0, '0);
    chk("z_busy", 64'(busy_a), 64'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, '0, '0);
      chk("z_done", 64'(done_a), (i == 3) ? 64'd1 : 64'd0);
    end
    chk("z_busy_end", 64'(busy_a), 64'd0);
    chk("z_fail", 64'(fail_a), 64'd0);
    chk("z_cnt",  64'(cnt_a),  64'd0);
    chk("z_sig",  64'(sig_a),  64'd0);

    // signature, resp=1 on sample 0
    cyc(1, 0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, '0, (i == 0) ? 39'h1 : 39'h0);
      chk("sig_lsb", 64'(sig_a), exp_sig(sig_tab_a[i]));
    end

    // signature, resp=1<<38 on sample 0 exercises the feedback taps
    cyc(1, 0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, '0, (i == 0) ? (39'h1 << 38) : 39'h0);
      chk("sig_msb", 64'(sig_a), exp_sig(sig_tab_b[i]));
    end
    chk("sig_msb_done", 64'(done_a), 64'd1);

    // first-failure capture
    cyc(1, 0, '0, '0);
    for (int i = 0; i < 4; i++) cyc(0, 1, dv[i], '0);
    chk("ff_fail", 64'(fail_a), 64'd1);
    chk("ff_cnt",  64'(cnt_a),  64'd2);
    chk("ff_idx",  64'(ffi_a),  64'd1);
    chk("ff_vec",  64'(ffv_a),  64'h5);
    chk("ff_done", 64'(done_a), 64'd1);
    cyc(0, 1, 39'h3, 39'h1);
    chk("done_hold_cnt", 64'(cnt_a), 64'd2);
    chk("done_hold_vec", 64'(ffv_a), 64'h5);
    chk("done_hold_sig", 64'(sig_a), 64'd0);
    chk("done_hold",     64'(done_a), 64'd1);

    // saturation on the 3-bit counter
    cyc(1, 0, '0, '0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 39'h1, '0);
      if (i == 6) chk("sat_cnt7", 64'(cnt_b), 64'd7);
    end
    chk("sat_cnt_hold", 64'(cnt_b), 64'd7);
    chk("sat_done",     64'(done_b), 64'd1);
    chk("sat_ffi",      64'(ffi_b),  64'd0);

    // asynchronous reset mid-session
    cyc(1, 0, '0, '0);
    cyc(0, 1, 39'h1, 39'h1);
    cyc(0, 1, 39'h1, 39'h1);
    chk("pre_rst_cnt", 64'(cnt_a), 64'd2);
    #2 RST = 1'b1;
    #1;
    chk("arst_busy", 64'(busy_a), 64'd0);
    chk("arst_fail", 64'(fail_a), 64'd0);
    chk("arst_cnt",  64'(cnt_a),  64'd0);
    chk("arst_ffv",  64'(ffv_a),  64'd0);
    chk("arst_sig",  64'(sig_a),  64'd0);
    chk("arst_cntb", 64'(cnt_b),  64'd0);
    RST = 1'b0;
    cyc(0, 1, 39'h1, 39'h1);
    chk("post_rst_busy", 64'(busy_a), 64'd0);
    chk("post_rst_fail", 64'(fail_a), 64'd0);

    // start and valid together: sample dropped, session restarts
    cyc(1, 0, '0, '0);
    cyc(0, 1, 39'h1, '0);
    chk("sv_pre_cnt", 64'(cnt_a), 64'd1);
    cyc(1, 1, 39'h1, 39'h1);
    chk("sv_cnt",  64'(cnt_a),  64'd0);
    chk("sv_fail", 64'(fail_a), 64'd0);
    chk("sv_busy", 64'(busy_a), 64'd1);
    chk("sv_sig",  64'(sig_a),  64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, '0, '0);
      chk("sv_done", 64'(done_a), (i == 3) ? 64'd1 : 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
